// File: rtl/baseline_avg_pkg.sv
// rtl/baseline_avg_pkg.sv - shared types and sizing helpers for the baseline estimator
package baseline_avg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_HOLD,
    ST_TRACK
  } bl_state_t;

  localparam int SETTLE_CW = 8;

  // The sum of 2^lnavg unsigned dw-bit samples always fits here.
  function automatic int acc_width(input int dw, input int lnavg);
    return dw + lnavg;
  endfunction

endpackage

// File: rtl/baseline_avg_ch.sv
// rtl/baseline_avg_ch.sv - per-channel accumulator, boxcar mean and IIR tracking datapath
module baseline_avg_ch
  import baseline_avg_pkg::*;
#(
  parameter int DW    = 14,
  parameter int LNAVG = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          acc_en,
  input  logic          fin_en,
  input  logic          trk_en,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] baseline
);

  localparam int AW = acc_width(DW, LNAVG);

  logic [AW-1:0]        acc;
  logic [AW-1:0]        acc_sum;
  logic [DW-1:0]        mean;
  logic signed [DW:0]   diff;
  logic signed [DW:0]   step;
  logic signed [DW:0]   iir_next;

  assign acc_sum  = acc + AW'(sample);
  assign mean     = acc_sum[AW-1:LNAVG];

  // Signed DW+1 bits hold x-b exactly; the arithmetic shift floors toward -inf,
  // so the update never overshoots either endpoint.
  assign diff     = $signed({1'b0, sample}) - $signed({1'b0, baseline});
  assign step     = diff >>> LNAVG;
  assign iir_next = $signed({1'b0, baseline}) + step;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      baseline <= '0;
    end else begin
      if (clr || fin_en) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc_sum;
      end

      if (fin_en) begin
        baseline <= mean;
      end else if (trk_en) begin
        baseline <= iir_next[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/baseline_avg_mc.sv
// rtl/baseline_avg_mc.sv - multi-channel ADC baseline estimator: restart FSM, counters and status
module baseline_avg_mc
  import baseline_avg_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DW      = 14,
  parameter int LNAVG   = 2,
  parameter int NSETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dacset,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] indata,
  input  logic              mode_track,
  output logic [NCH*DW-1:0] baseline,
  output logic              done,
  output logic              bl_valid,
  output logic              busy
);

  localparam logic [SETTLE_CW-1:0] SETTLE_LAST =
    SETTLE_CW'((NSETTLE == 0) ? 0 : NSETTLE - 1);

  bl_state_t              state;
  logic                   dacset_q;
  logic [SETTLE_CW-1:0]   settle_cnt;
  logic [LNAVG-1:0]       samp_cnt;
  logic                   fall;
  logic                   run;
  logic                   last;
  logic                   clr;
  logic                   acc_en;
  logic                   fin_en;
  logic                   trk_en;

  assign fall   = dacset_q & ~dacset;
  assign run    = ~dacset & ~fall;
  assign last   = &samp_cnt;
  assign clr    = dacset | fall;
  assign acc_en = run && (state == ST_ACCUM) && in_valid && !last;
  assign fin_en = run && (state == ST_ACCUM) && in_valid && last;
  assign trk_en = run && (state == ST_TRACK) && in_valid && mode_track;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      dacset_q   <= 1'b0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      done       <= 1'b0;
      bl_valid   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      dacset_q <= dacset;
      bl_valid <= 1'b0;
      if (dacset) begin
        state      <= ST_IDLE;
        settle_cnt <= '0;
        samp_cnt   <= '0;
        done       <= 1'b0;
        busy       <= 1'b0;
      end else if (fall) begin
        state      <= ST_SETTLE;
        settle_cnt <= '0;
        samp_cnt   <= '0;
        busy       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_SETTLE: begin
            busy <= 1'b1;
            if (NSETTLE == 0) begin
              state <= ST_ACCUM;
            end else if (in_valid) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                state      <= ST_ACCUM;
              end else begin
                settle_cnt <= settle_cnt + SETTLE_CW'(1);
              end
            end
          end
          ST_ACCUM: begin
            if (in_valid) begin
              if (last) begin
                samp_cnt <= '0;
                bl_valid <= 1'b1;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= mode_track ? ST_TRACK : ST_HOLD;
              end else begin
                samp_cnt <= samp_cnt + LNAVG'(1);
              end
            end
          end
          ST_HOLD: begin
            busy <= 1'b0;
            if (mode_track) state <= ST_TRACK;
          end
          ST_TRACK: begin
            busy <= 1'b0;
            if (!mode_track) begin
              state <= ST_HOLD;
            end else if (in_valid) begin
              bl_valid <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    baseline_avg_ch #(
      .DW    (DW),
      .LNAVG (LNAVG)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .acc_en   (acc_en),
      .fin_en   (fin_en),
      .trk_en   (trk_en),
      .sample   (indata[k*DW +: DW]),
      .baseline (baseline[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_baseline_avg_mc.sv
// tb/tb_baseline_avg_mc.sv - self-checking bench for baseline_avg_mc (NSETTLE=0 and NSETTLE=3 instances)
`timescale 1ns/1ps
module tb_baseline_avg_mc;

  localparam int DW  = 14;
  localparam int NCH = 2;
  localparam int NAVG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              dacset;
  logic              in_valid;
  logic [NCH*DW-1:0] indata;
  logic              mode_track;

  logic [NCH*DW-1:0] bl_a, bl_b;
  logic              done_a, done_b, blv_a, blv_b, busy_a, busy_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  baseline_avg_mc #(.NCH(NCH), .DW(DW), .LNAVG(2), .NSETTLE(0)) dut_a (
    .clk(clk), .rst(rst), .dacset(dacset), .in_valid(in_valid), .indata(indata),
    .mode_track(mode_track), .baseline(bl_a), .done(done_a), .bl_valid(blv_a), .busy(busy_a)
  );

  baseline_avg_mc #(.NCH(NCH), .DW(DW), .LNAVG(2), .NSETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .dacset(dacset), .in_valid(in_valid), .indata(indata),
    .mode_track(mode_track), .baseline(bl_b), .done(done_b), .bl_valid(blv_b), .busy(busy_b)
  );

  function automatic int ch(input logic [NCH*DW-1:0] v, input int k);
    return int'(v[k*DW +: DW]);
  endfunction

  function automatic int floor_div(input int d, input int n);
    if (d >= 0) return d / n;
    return -((-d + n - 1) / n);
  endfunction

  function automatic int iir(input int b, input int x);
    return b + floor_div(x - b, NAVG);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int x0, input int x1);
    logic [DW-1:0] a, b;
    a = DW'(x0);
    b = DW'(x1);
    in_valid = v;
    indata   = {b, a};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    dacset = 1'b1;
    step(1'b0, 0, 0);
    dacset = 1'b0;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0[4];
    int s0[4], s1[4];
    int e0, e1, x0, x1;

    t0 = '{100, 104, 108, 112};
    rst = 1'b1; dacset = 1'b0; in_valid = 1'b0; indata = '0; mode_track = 1'b0;
    @(negedge clk);
    step(1'b0, 0, 0);
    chk("rst_baseline", int'(bl_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_blv", int'(blv_a), 0);
    chk("rst_busy", int'(busy_a), 1);
    rst = 1'b0;
    step(1'b0, 0, 0);
    chk("post_rst_busy", int'(busy_a), 1);

    // contiguous boxcar with full-scale channel 1
    for (int i = 0; i < 4; i++) begin
      step(1'b1, t0[i], 16383);
      chk("t1_blv", int'(blv_a), (i == 3) ? 1 : 0);
    end
    e0 = (t0[0] + t0[1] + t0[2] + t0[3]) / NAVG;
    e1 = 16383;
    chk("t1_ch0", ch(bl_a, 0), e0);
    chk("t1_ch1", ch(bl_a, 1), e1);
    chk("t1_done", int'(done_a), 1);
    step(1'b0, 0, 0);
    chk("t1_blv_single", int'(blv_a), 0);
    chk("t1_busy", int'(busy_a), 0);

    // IIR tracking: directed points then random back-to-back samples
    mode_track = 1'b1;
    step(1'b0, 0, 0);
    step(1'b1, 206, 16383);
    e0 = iir(e0, 206); e1 = iir(e1, 16383);
    chk("t2_ch0_206", ch(bl_a, 0), e0);
    chk("t2_ch1_206", ch(bl_a, 1), e1);
    step(1'b1, 0, 16383);
    e0 = iir(e0, 0); e1 = iir(e1, 16383);
    chk("t2_ch0_0", ch(bl_a, 0), e0);
    for (int i = 0; i < 10; i++) begin
      x0 = int'($urandom_range(16383, 0));
      x1 = int'($urandom_range(16383, 0));
      step(1'b1, x0, x1);
      e0 = iir(e0, x0); e1 = iir(e1, x1);
      chk("trk_ch0", ch(bl_a, 0), e0);
      chk("trk_ch1", ch(bl_a, 1), e1);
      chk("trk_blv", int'(blv_a), 1);
    end
    mode_track = 1'b0;
    step(1'b1, 5, 5);
    chk("trk_exit_ch0", ch(bl_a, 0), e0);
    chk("trk_exit_blv", int'(blv_a), 0);
    step(1'b1, 9000, 9000);
    chk("hold_ch1", ch(bl_a, 1), e1);

    // restart mid-accumulation discards partial sums
    restart();
    chk("t3_done_clear", int'(done_a), 0);
    step(1'b1, 16000, 16000);
    step(1'b1, 16000, 16000);
    dacset = 1'b1;
    step(1'b1, 3, 3);
    chk("t3_dacset_done", int'(done_a), 0);
    chk("t3_retain", ch(bl_a, 0), e0);
    dacset = 1'b0;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      s1[i] = int'($urandom_range(16383, 0));
      step(1'b1, 50, s1[i]);
    end
    chk("t3_ch0", ch(bl_a, 0), 50);
    chk("t3_ch1", ch(bl_a, 1), (s1[0] + s1[1] + s1[2] + s1[3]) / NAVG);
    chk("t3_done", int'(done_a), 1);

    // random boxcar rounds
    for (int r = 0; r < 3; r++) begin
      restart();
      for (int i = 0; i < 4; i++) begin
        s0[i] = int'($urandom_range(16383, 0));
        s1[i] = int'($urandom_range(16383, 0));
        step(1'b1, s0[i], s1[i]);
      end
      chk("rnd_ch0", ch(bl_a, 0), (s0[0] + s0[1] + s0[2] + s0[3]) / NAVG);
      chk("rnd_ch1", ch(bl_a, 1), (s1[0] + s1[1] + s1[2] + s1[3]) / NAVG);
    end

    // settle discard on the NSETTLE=3 instance
    restart();
    for (int i = 0; i < 7; i++) begin
      x0 = (i < 3) ? 5000 : 200;
      step(1'b1, x0, x0);
      chk("t4_busy", int'(busy_b), (i < 6) ? 1 : 0);
    end
    chk("t4_ch0", ch(bl_b, 0), 200);
    chk("t4_ch1", ch(bl_b, 1), 200);
    chk("t4_done", int'(done_b), 1);
    chk("t4_nosettle_ch0", ch(bl_a, 0), (3 * 5000 + 200) / NAVG);

    // gapped in_valid
    restart();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, t0[i], 16383);
      chk("t5_blv", int'(blv_a), (i == 3) ? 1 : 0);
      step(1'b0, 7777, 7777);
      chk("t5_blv_gap", int'(blv_a), 0);
    end
    e0 = (t0[0] + t0[1] + t0[2] + t0[3]) / NAVG;
    chk("t5_ch0", ch(bl_a, 0), e0);
    chk("t5_ch1", ch(bl_a, 1), 16383);

    // reset while tracking
    mode_track = 1'b1;
    step(1'b0, 0, 0);
    step(1'b1, 300, 300);
    chk("t6_trk", ch(bl_a, 0), iir(e0, 300));
    rst = 1'b1;
    step(1'b1, 400, 400);
    chk("t6_baseline", int'(bl_a), 0);
    chk("t6_done", int'(done_a), 0);
    chk("t6_blv", int'(blv_a), 0);
    chk("t6_busy", int'(busy_a), 1);
    rst = 1'b0;
    step(1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
